alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Control stage directly upstream of the 8-bit ALU.
- Accepts register-to-register instructions over a valid/ready handshake and holds a 4-entry × 8-bit register file.
- Drives the ALU operand and operation inputs for one cycle, then writes the ALU result back with zero/carry flags.
- Sits between the instruction decoder and the ALU; one instruction completes every 3 cycles.

## Interface
Parameters:
- none; widths fixed (8-bit data, 4 registers, 4-bit opcode)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction valid
- in_ready  out  1  sequencer can accept
- in_opcode  in  4  4'b0001 ADD, 4'b0011 SUB, 4'b1000 LDI (macro-gated)
- in_dst  in  2  destination register index
- in_srca  in  2  source A register index
- in_srcb  in  2  source B register index
- in_imm  in  8  immediate for LDI
- alu_a  out  8  ALU operand A (registered)
- alu_b  out  8  ALU operand B (registered)
- alu_op  out  4  ALU operation (registered)
- alu_sub  out  1  1 when alu_op is SUB
- alu_cin  out  1  constant 0
- alu_sum  in  8  ALU result, combinational from alu_a/alu_b/alu_op
- done  out  1  one-cycle completion pulse
- err  out  1  illegal opcode, valid with done
- result  out  8  last written value
- flag_z  out  1  zero flag
- flag_c  out  1  carry (ADD) / borrow (SUB)
- rd_sel  in  2  debug read index
- rd_data  out  8  combinational regfile[rd_sel]

## Operation
States and transitions:
- IDLE → EXEC on in_valid && in_ready.
- EXEC → DONE unconditionally.
- DONE → IDLE unconditionally.
- in_ready = (state == IDLE).

On accept (edge ending IDLE):
- alu_a ← reg[in_srca], alu_b ← reg[in_srcb].
- alu_op ← in_opcode if legal ALU op, else 4'b0000.
- Latch dst, opcode and imm.

In EXEC, the ALU settles. On the edge ending EXEC:
- ADD/SUB: reg[dst] ← alu_sum; result ← alu_sum; flag_z ← (alu_sum == 0).
- flag_c: ADD ← 9-bit (alu_a + alu_b) bit 8; SUB ← (alu_a < alu_b). Computed internally from the registered operands, not from an ALU output.
- Illegal opcode: no register write, flags and result unchanged, err set.

DONE:
- done = 1, err valid; both clear on exit.
- alu_op returns to 4'b0000 on entering DONE.
- alu_a/alu_b hold their last values.

Register-file rules:
- Source equal to destination reads the old value.
- The next instruction sees the written value, since writeback precedes the next accept.
- Arithmetic wraps modulo 256.

## Timing
- Handshake edge at cycle T → EXEC in T+1 → done high in T+2 → in_ready high in T+3.
- Throughput is 1 instruction per 3 cycles; in_valid held while in_ready = 0 is ignored.
- Reset values: state IDLE, in_ready 1, all regs 0, alu_a/alu_b/alu_op 0, alu_sub 0, done 0, err 0, result 0, flag_z 0, flag_c 0.
- Reset asserted mid-instruction: immediate return to IDLE, no writeback, no done pulse.

## Configuration
ALU_SEQ_LOAD_IMM_EN
- Defined: opcode 4'b1000 is LDI. It follows the same 3-cycle path with alu_op = 0 during EXEC. On the edge ending EXEC: reg[dst] ← imm, result ← imm, flag_z ← (imm == 0), flag_c ← 0, err 0.
- Undefined: 4'b1000 is illegal, giving err = 1 and no write.

## Test plan
- Reset, then ADD r0 = r1 + r2 with all regs 0 → done at T+2, result 0, flag_z 1, flag_c 0, err 0.
- (LDI enabled) LDI r1 = 200, LDI r2 = 100, ADD r3 = r1 + r2:
  - EXEC shows alu_a 200, alu_b 100, alu_op 0001.
  - Result 44, flag_c 1, flag_z 0, rd_sel 3 → rd_data 44.
- SUB r0 = r2 − r1 with r2 = 100, r1 = 200 → alu_sub 1 in EXEC, result 156, flag_c 1; r1 − r1 → result 0, flag_z 1, flag_c 0.
- Opcode 4'b0111 with flags preset → done and err 1 at T+2, registers and flags unchanged; following legal op has err 0.
- Hold in_valid continuously for two ADDs → in_ready low T+1..T+2, second accept at T+3, second done at T+5.
- Assert rst_n low during EXEC → no write to dst, done never pulses, all outputs at reset values, in_ready 1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Three-cycle IDLE/EXEC/DONE sequencer feeding an external 8-bit ALU from a 4x8 register file.
// Define ALU_SEQ_LOAD_IMM_EN to make opcode 4'b1000 a load-immediate (LDI); otherwise it is illegal.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_opcode,
  input  logic [1:0] in_dst,
  input  logic [1:0] in_srca,
  input  logic [1:0] in_srcb,
  input  logic [7:0] in_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_sub,
  output logic       alu_cin,
  input  logic [7:0] alu_sum,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_c,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b1000;

`ifdef ALU_SEQ_LOAD_IMM_EN
  localparam logic LDI_EN = 1'b1;
`else
  localparam logic LDI_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] regs_q [4];
  logic [7:0] alu_a_q, alu_b_q;
  logic [3:0] alu_op_q;
  logic [1:0] dst_q;
  logic [3:0] opc_q;
  logic [7:0] imm_q;
  logic [7:0] result_q;
  logic       flag_z_q, flag_c_q, err_q;

  logic       accept;
  logic       wb_en_d, ill_d, flag_c_d;
  logic [7:0] wb_data_d;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    done     = (state_q == S_DONE);
    err      = (state_q == S_DONE) && err_q;
  end

  // Writeback decode; carry/borrow comes from the registered operands, not the ALU.
  always_comb begin
    wb_en_d   = 1'b0;
    ill_d     = 1'b0;
    flag_c_d  = 1'b0;
    wb_data_d = alu_sum;
    if (opc_q == OP_ADD) begin
      wb_en_d  = 1'b1;
      flag_c_d = ({1'b0, alu_a_q} + {1'b0, alu_b_q}) > 9'd255;
    end else if (opc_q == OP_SUB) begin
      wb_en_d  = 1'b1;
      flag_c_d = (alu_a_q < alu_b_q);
    end else if (LDI_EN && (opc_q == OP_LDI)) begin
      wb_en_d   = 1'b1;
      wb_data_d = imm_q;
    end else begin
      ill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_NOP;
      dst_q    <= '0;
      opc_q    <= '0;
      imm_q    <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_q  <= regs_q[in_srca];
        alu_b_q  <= regs_q[in_srcb];
        alu_op_q <= ((in_opcode == OP_ADD) || (in_opcode == OP_SUB)) ? in_opcode : OP_NOP;
        dst_q    <= in_dst;
        opc_q    <= in_opcode;
        imm_q    <= in_imm;
      end
      if (state_q == S_EXEC) begin
        alu_op_q <= OP_NOP;
        err_q    <= ill_d;
        if (wb_en_d) begin
          regs_q[dst_q] <= wb_data_d;
          result_q      <= wb_data_d;
          flag_z_q      <= (wb_data_d == 8'd0);
          flag_c_q      <= flag_c_d;
        end
      end
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign alu_sub = (alu_op_q == OP_SUB);
  assign alu_cin = 1'b0;
  assign result  = result_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign rd_data = regs_q[rd_sel];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer; models the ALU and a reference register file.
module tb_alu_op_sequencer;

  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0011;
  localparam logic [3:0] LDI = 4'b1000;
  localparam logic [3:0] BAD = 4'b0111;

`ifdef ALU_SEQ_LOAD_IMM_EN
  localparam bit LDI_ON = 1'b1;
`else
  localparam bit LDI_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [1:0] in_dst, in_srca, in_srcb;
  logic [7:0] in_imm;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic       alu_sub, alu_cin;
  logic [7:0] alu_sum;
  logic       done, err;
  logic [7:0] result;
  logic       flag_z, flag_c;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dst(in_dst), .in_srca(in_srca), .in_srcb(in_srcb),
    .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sub(alu_sub), .alu_cin(alu_cin), .alu_sum(alu_sum), .done(done),
    .err(err), .result(result), .flag_z(flag_z), .flag_c(flag_c),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // ALU model; inj_en lets a step force the ALU output to seed registers without LDI.
  logic       inj_en;
  logic [7:0] inj_v;
  always_comb begin
    alu_sum = 8'hA5;
    if (inj_en) alu_sum = inj_v;
    else if (alu_op == ADD) alu_sum = alu_a + alu_b;
    else if (alu_op == SUB) alu_sum = alu_a - alu_b;
  end

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_regs [4];
  logic [7:0] m_res;
  logic       m_z, m_c;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_res = '0;
    m_z   = 1'b0;
    m_c   = 1'b0;
  endtask

  task automatic model_push(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                            input logic [1:0] b, input logic [7:0] imm, input bit inj,
                            input logic [7:0] injv);
    logic [7:0] va, vb, r;
    bit         wr;
    exp_t       e;
    va = m_regs[a];
    vb = m_regs[b];
    r  = '0;
    wr = 1'b0;
    if (op == ADD) begin
      r   = inj ? injv : 8'(va + vb);
      m_c = ({1'b0, va} + {1'b0, vb}) > 9'd255;
      wr  = 1'b1;
    end else if (op == SUB) begin
      r   = inj ? injv : 8'(va - vb);
      m_c = (va < vb);
      wr  = 1'b1;
    end else if (LDI_ON && op == LDI) begin
      r   = imm;
      m_c = 1'b0;
      wr  = 1'b1;
    end
    if (wr) begin
      m_regs[d] = r;
      m_res     = r;
      m_z       = (r == 8'd0);
    end
    e.res = m_res;
    e.z   = m_z;
    e.c   = m_c;
    e.e   = !wr;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_done: observed done=1 expected no pulse");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_flag_z", 8'(flag_z), 8'(e.z));
        chk("sb_flag_c", 8'(flag_c), 8'(e.c));
        chk("sb_err", 8'(err), 8'(e.e));
      end
    end
  end

  task automatic check_reg(input string tag, input logic [1:0] idx);
    rd_sel = idx;
    #1;
    chk(tag, rd_data, m_regs[idx]);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [7:0] imm, input bit inj,
                       input logic [7:0] injv);
    logic [7:0] ea, eb;
    logic [3:0] eop;
    int         n;
    ea  = m_regs[a];
    eb  = m_regs[b];
    eop = (op == ADD || op == SUB) ? op : 4'b0000;
    n   = 0;
    while (in_ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_issue", 8'(in_ready), 8'd1);
    model_push(op, d, a, b, imm, inj, injv);
    inj_en    = inj;
    inj_v     = injv;
    in_opcode = op;
    in_dst    = d;
    in_srca   = a;
    in_srcb   = b;
    in_imm    = imm;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_op", 8'(alu_op), 8'(eop));
    chk("exec_alu_sub", 8'(alu_sub), 8'(op == SUB));
    chk("exec_ready", 8'(in_ready), 8'd0);
    chk("exec_done", 8'(done), 8'd0);
    @(posedge clk); #1;
    chk("done_pulse", 8'(done), 8'd1);
    chk("done_alu_op", 8'(alu_op), 8'd0);
    chk("done_ready", 8'(in_ready), 8'd0);
    inj_en = 1'b0;
    @(posedge clk); #1;
    chk("post_done", 8'(done), 8'd0);
    chk("post_err", 8'(err), 8'd0);
    chk("post_ready", 8'(in_ready), 8'd1);
    check_reg("wb_reg", d);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_dst = '0; in_srca = '0;
    in_srcb = '0; in_imm = '0; rd_sel = '0; inj_en = 1'b0; inj_v = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 8'(in_ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_alu_a", alu_a, 8'd0);
    chk("rst_alu_b", alu_b, 8'd0);
    chk("rst_alu_op", 8'(alu_op), 8'd0);
    chk("rst_alu_sub", 8'(alu_sub), 8'd0);
    chk("rst_alu_cin", 8'(alu_cin), 8'd0);
    chk("rst_result", result, 8'd0);
    chk("rst_flags", {6'd0, flag_z, flag_c}, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i));

    issue(ADD, 2'd0, 2'd1, 2'd2, 8'd0, 1'b0, 8'd0);
    chk("add0_flag_z", 8'(flag_z), 8'd1);

    // Seed r1=200, r2=100 through LDI when present, else through the ALU path.
    if (LDI_ON) begin
      issue(LDI, 2'd1, 2'd0, 2'd0, 8'd200, 1'b0, 8'd0);
      issue(LDI, 2'd2, 2'd0, 2'd0, 8'd100, 1'b0, 8'd0);
    end else begin
      issue(ADD, 2'd1, 2'd0, 2'd0, 8'd0, 1'b1, 8'd200);
      issue(ADD, 2'd2, 2'd0, 2'd0, 8'd0, 1'b1, 8'd100);
    end

    issue(ADD, 2'd3, 2'd1, 2'd2, 8'd0, 1'b0, 8'd0);
    rd_sel = 2'd3; #1;
    chk("add_wrap_rd3", rd_data, 8'd44);
    chk("add_wrap_c", 8'(flag_c), 8'd1);

    issue(SUB, 2'd0, 2'd2, 2'd1, 8'd0, 1'b0, 8'd0);
    chk("sub_borrow_result", result, 8'd156);

    issue(BAD, 2'd2, 2'd1, 2'd1, 8'd0, 1'b0, 8'd0);
    chk("bad_result_kept", result, 8'd156);
    chk("bad_c_kept", 8'(flag_c), 8'd1);
    for (int i = 0; i < 4; i++) check_reg("bad_regs", 2'(i));

    issue(SUB, 2'd0, 2'd1, 2'd1, 8'd0, 1'b0, 8'd0);
    chk("sub_self_z", 8'(flag_z), 8'd1);

    issue(LDI, 2'd0, 2'd3, 2'd3, 8'd0, 1'b0, 8'd0);
    issue(SUB, 2'd1, 2'd1, 2'd2, 8'd0, 1'b0, 8'd0);
    chk("src_eq_dst_r1", m_regs[1], 8'd100);

    // Held in_valid: ADD r1=r1+r2 accepted at T, then again at T+3 using the written r1.
    model_push(ADD, 2'd1, 2'd1, 2'd2, 8'd0, 1'b0, 8'd0);
    in_opcode = ADD; in_dst = 2'd1; in_srca = 2'd1; in_srcb = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("hold_t1_ready", 8'(in_ready), 8'd0);
    chk("hold_t1_alu_a", alu_a, 8'd100);
    @(posedge clk); #1;
    chk("hold_t2_ready", 8'(in_ready), 8'd0);
    chk("hold_t2_done", 8'(done), 8'd1);
    @(posedge clk); #1;
    chk("hold_t3_ready", 8'(in_ready), 8'd1);
    model_push(ADD, 2'd1, 2'd1, 2'd2, 8'd0, 1'b0, 8'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_t4_alu_a", alu_a, 8'd200);
    chk("hold_t4_ready", 8'(in_ready), 8'd0);
    @(posedge clk); #1;
    chk("hold_t5_done", 8'(done), 8'd1);
    @(posedge clk); #1;
    check_reg("hold_r1", 2'd1);

    // Reset during EXEC: nothing written, no done pulse.
    in_opcode = ADD; in_dst = 2'd0; in_srca = 2'd1; in_srcb = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_exec_op", 8'(alu_op), 8'(ADD));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_ready", 8'(in_ready), 8'd1);
    chk("mrst_alu_a", alu_a, 8'd0);
    chk("mrst_alu_op", 8'(alu_op), 8'd0);
    chk("mrst_result", result, 8'd0);
    chk("mrst_flags", {6'd0, flag_z, flag_c}, 8'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mrst_no_done", 8'(done), 8'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) check_reg("mrst_regs", 2'(i));
    repeat (2) begin
      @(posedge clk); #1;
      chk("mrst_idle_done", 8'(done), 8'd0);
    end

    issue(ADD, 2'd0, 2'd1, 2'd2, 8'd0, 1'b0, 8'd0);
    @(posedge clk); #1;
    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
